// File: rtl/holding_skid_buffer_if.sv
// rtl/holding_skid_buffer_if.sv - handshake bundle for the holding skid buffer
//
// Purpose: groups the upstream push side, downstream pop side, flush and
// occupancy of holding_skid_buffer into one interface.
//
// Signals:
//   in_data   [WIDTH]  word offered by the upstream stage
//   in_valid           in_data is valid this cycle
//   in_ready           buffer can accept a word this cycle
//   out_data  [WIDTH]  oldest buffered word
//   out_valid          out_data is valid
//   out_ready          downstream accepts out_data this cycle
//   flush              synchronous discard of all buffered words
//   count     [2]      number of words held (0..2)
//
// Modports:
//   slave  - the buffer itself
//   master - the environment driving it (upstream + downstream together)

interface holding_skid_buffer_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  logic [1:0]       count;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    input  flush,
    output count
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    output flush,
    input  count
  );

endinterface

// File: rtl/holding_skid_buffer.sv
// rtl/holding_skid_buffer.sv - two-entry registered elastic buffer (main + skid)
//
// Purpose: accepts words from an upstream stage and presents them, in order,
// to a downstream stage. A second (skid) register absorbs one cycle of
// downstream stall. Every output is driven from a register, so there is no
// combinational path from in_* to out_* nor from out_ready to in_ready.
//
// Ports:
//   clk    input   rising-edge clock
//   reset  input   asynchronous active-low reset (0 = in reset)
//   bus    slave   holding_skid_buffer_if: in_data/in_valid/in_ready,
//                  out_data/out_valid/out_ready, flush, count

module holding_skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  holding_skid_buffer_if.slave  bus
);

  // The state encoding is the occupancy, so count is the state register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] main_q,     main_d;
  logic [WIDTH-1:0] skid_q,     skid_d;
  logic             in_ready_q, in_ready_d;

  logic push;
  logic pop;

  // in_ready is its own register (rather than decoded from state_q) so that
  // it reads 0 while in reset and rises only at the first edge after release.
  assign push = bus.in_valid & in_ready_q;
  assign pop  = (state_q != EMPTY) & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (bus.flush) begin
      // Flush beats any transfer; main_q is left alone so out_data holds.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = bus.in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = bus.in_data;
          end else if (push) begin
            state_d = FULL;
            skid_d  = bus.in_data;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready_q is 0 here, so push cannot occur.
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end

    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.count     = state_q;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = main_q;
  assign bus.in_ready  = in_ready_q;

endmodule

// File: tb/tb_holding_skid_buffer.sv
// tb/tb_holding_skid_buffer.sv - directed self-checking bench for holding_skid_buffer

module tb_holding_skid_buffer;

  logic clk;
  logic reset;

  int errors;
  int checks;

  holding_skid_buffer_if #(.WIDTH(32)) bus ();

  holding_skid_buffer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [1:0] cnt, input logic ov,
                              input logic ir, input logic [31:0] data);
    check({tag, ".count"},     {30'd0, bus.count}, {30'd0, cnt});
    check({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, ov});
    check({tag, ".in_ready"},  {31'd0, bus.in_ready}, {31'd0, ir});
    check({tag, ".out_data"},  bus.out_data, data);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset         = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    // Reset / idle
    repeat (3) step();
    expect_state("rst", 2'd0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    #1;
    check("rst.in_ready_before_edge", {31'd0, bus.in_ready}, 32'd0);
    step();
    expect_state("idle", 2'd0, 1'b0, 1'b1, 32'h0);

    // Streaming 1..5 with out_ready=1
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.in_data = i;
      step();
      expect_state($sformatf("stream%0d", i), 2'd1, 1'b1, 1'b1, i);
    end
    bus.in_valid = 1'b0;
    step();
    expect_state("stream_drain", 2'd0, 1'b0, 1'b1, 32'h5);

    // Stall / fill
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hAAAA0001;
    step();
    expect_state("fill1", 2'd1, 1'b1, 1'b1, 32'hAAAA0001);
    bus.in_data = 32'hAAAA0002;
    step();
    expect_state("fill2", 2'd2, 1'b1, 1'b0, 32'hAAAA0001);
    // Upstream keeps offering while blocked: must not be accepted.
    bus.in_data = 32'hBBBB0003;
    step();
    expect_state("full_hold", 2'd2, 1'b1, 1'b0, 32'hAAAA0001);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    expect_state("drain1", 2'd1, 1'b1, 1'b1, 32'hAAAA0002);
    step();
    expect_state("drain2", 2'd0, 1'b0, 1'b1, 32'hAAAA0002);

    // Simultaneous push/pop in ONE
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h12345678;
    step();
    expect_state("pp_load", 2'd1, 1'b1, 1'b1, 32'h12345678);
    bus.out_ready = 1'b1;
    bus.in_data   = 32'hDEADBEEF;
    step();
    expect_state("pp_swap", 2'd1, 1'b1, 1'b1, 32'hDEADBEEF);
    bus.in_valid = 1'b0;
    step();
    expect_state("pp_drain", 2'd0, 1'b0, 1'b1, 32'hDEADBEEF);

    // Flush with full buffer plus a push attempt
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h00001111;
    step();
    bus.in_data = 32'h00002222;
    step();
    expect_state("fl_full", 2'd2, 1'b1, 1'b0, 32'h00001111);
    bus.flush   = 1'b1;
    bus.in_data = 32'h00003333;
    step();
    expect_state("fl_done", 2'd0, 1'b0, 1'b1, 32'h00001111);
    bus.flush   = 1'b0;
    bus.in_data = 32'h0000CAFE;
    step();
    expect_state("fl_next", 2'd1, 1'b1, 1'b1, 32'h0000CAFE);

    // Flush in ONE with an accepted push and a pop: both are discarded
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    bus.in_data   = 32'h0BAD0BAD;
    step();
    expect_state("fl_one", 2'd0, 1'b0, 1'b1, 32'h0000CAFE);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    step();
    expect_state("fl_idle", 2'd0, 1'b0, 1'b1, 32'h0000CAFE);

    // Async reset mid-stream with count=2
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h00000A01;
    step();
    bus.in_data = 32'h00000A02;
    step();
    bus.in_valid = 1'b0;
    expect_state("ar_full", 2'd2, 1'b1, 1'b0, 32'h00000A01);
    #2;
    reset = 1'b0;
    #1;
    expect_state("ar_async", 2'd0, 1'b0, 1'b0, 32'h0);
    step();
    reset = 1'b1;
    step();
    expect_state("ar_release", 2'd0, 1'b0, 1'b1, 32'h0);

    // Confirm the skid register was cleared: a fresh fill/drain shows new data only
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h00000B01;
    step();
    bus.in_data = 32'h00000B02;
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    expect_state("post_rst_skid", 2'd1, 1'b1, 1'b1, 32'h00000B02);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $finish;
  end

endmodule

// File: doc/holding_skid_buffer.md
Name: holding_skid_buffer

Overview:
- Consumer-side counterpart of the holding register: drains 32-bit words written by an upstream stage and presents them to a downstream stage through a valid/ready handshake.
- Two-entry registered elastic buffer (main + skid) that absorbs one cycle of downstream stall without losing data.
- Has no combinational path from input to output, and none from out_ready to in_ready.
- Sits between pipeline stages (e.g. fetch to decode) and supports a pipeline flush.

Parameters:
WIDTH, 32, data word width in bits

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
in_data  input  WIDTH  word offered by the upstream stage
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  buffer can accept a word this cycle
out_data  output  WIDTH  oldest buffered word
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts out_data this cycle
flush  input  1  synchronous discard of all buffered words
count  output  2  number of words held (0..2)

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is asynchronous and active-low.
- While reset=0:
  - state=EMPTY, count=0, out_valid=0, out_data=0, skid register=0, in_ready=0.
- After reset rises:
  - in_ready=1 from the first clk edge onward.
- Transfer rules:
  - push = in_valid & in_ready; pop = out_valid & out_ready, both sampled at the rising edge.
  - in_ready = (count != 2). It is decoded from registered state only and never depends on out_ready.
  - out_valid = (count != 0), registered.
  - out_data = main register. It holds its last value when out_valid=0.
- State machine (count encodes state):
  - EMPTY(0):
    - push -> ONE; main <= in_data.
  - ONE(1):
    - push & pop -> ONE; main <= in_data.
    - push & !pop -> FULL; skid <= in_data.
    - !push & pop -> EMPTY.
    - Otherwise hold.
  - FULL(2):
    - pop -> ONE; main <= skid.
    - Push is impossible (in_ready=0).
    - Otherwise hold.
- Ordering:
  - Strict FIFO: words leave in acceptance order. No drops, no duplicates.
- Latency:
  - A word accepted at edge N into an empty buffer has out_valid=1 with that word after edge N.
  - This is one cycle of latency.
- Throughput:
  - 1 word/cycle sustained while out_ready=1.
- Flush:
  - flush=1 at an edge forces EMPTY and count=0.
  - push and pop in that cycle are ignored; the accepted word is discarded.
  - out_data keeps its previous value.
  - in_ready=1 after the edge.
  - flush has priority over all transfers.
- Reset mid-operation:
  - All state clears immediately (asynchronous) and buffered words are lost.
- Backpressure:
  - in_valid=1 with in_ready=0 is not an error.
  - Upstream must hold in_data/in_valid stable until accepted.
- X-safety:
  - in_data is not sampled when push=0.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, then release -> out_valid=0, count=0, out_data=0; in_ready=1 after the first edge.
- Streaming: push 0x00000001..0x00000005 on consecutive cycles with out_ready=1 -> out_data shows 1..5 one cycle delayed, count stays 1, in_ready stays 1.
- Stall/fill: push 0xAAAA0001, then 0xAAAA0002 with out_ready=0 -> count=2, in_ready=0, out_data=0xAAAA0001. Set out_ready=1 for 2 cycles -> outputs 0xAAAA0001 then 0xAAAA0002, count returns to 0.
- Simultaneous push/pop in ONE: main=0x12345678, push 0xDEADBEEF with out_ready=1 -> next cycle out_data=0xDEADBEEF, count=1.
- Flush with full buffer plus a push attempt: count=2, assert flush with in_valid=1 -> count=0, out_valid=0, in_ready=1; the next push of 0x0000CAFE appears as the first output.
- Async reset mid-stream: drop reset between clock edges while count=2 -> out_valid, count and in_ready go to 0 immediately, without waiting for a clk edge.
